// File: rtl/servant_reset_seq.sv
// servant_reset_seq: PLL-lock driven reset sequencer.
// Synchronises and qualifies the lock input, holds resets for a fixed time,
// then releases CHANNELS active-high resets one after another. Loss of lock
// or a software request re-runs the sequence; lock losses seen while running
// are counted in a saturating debug counter.
module servant_reset_seq #(
  parameter int CHANNELS    = 2,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CYCLES = 16,
  parameter int HOLD_CYCLES = 8,
  parameter int STAGGER     = 4,
  parameter int LOSS_CNT_W  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_locked,
  input  logic                  i_sw_rst,
  output logic [CHANNELS-1:0]   o_rst,
  output logic                  o_ready,
  output logic [LOSS_CNT_W-1:0] o_lock_loss_cnt
);

  // One shared cycle counter covers the longest of the three waits.
  localparam int CNT_MAX0 = (LOCK_CYCLES > HOLD_CYCLES) ? LOCK_CYCLES : HOLD_CYCLES;
  localparam int CNT_MAX  = (CNT_MAX0 > STAGGER) ? CNT_MAX0 : STAGGER;
  localparam int CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(CHANNELS - 1);

  typedef enum logic [1:0] {QUALIFY, HOLD, RELEASE, RUN} state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [IDX_W-1:0]       idx;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;

  assign locked_s = sync_q[SYNC_STAGES-1];

  // Lock synchroniser: plain shift chain, oldest sample at the top.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], i_locked};
  end

  // Sequencer FSM; lock loss outranks the software request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= QUALIFY;
      cnt             <= '0;
      idx             <= '0;
      o_rst           <= '1;
      o_ready         <= 1'b0;
      o_lock_loss_cnt <= '0;
    end else if (state != QUALIFY && !locked_s) begin
      // Lock dropped after qualification: reassert everything, requalify.
      state   <= QUALIFY;
      cnt     <= '0;
      idx     <= '0;
      o_rst   <= '1;
      o_ready <= 1'b0;
      if (state == RUN && o_lock_loss_cnt != '1)
        o_lock_loss_cnt <= o_lock_loss_cnt + 1'b1;
    end else begin
      case (state)
        QUALIFY: begin
          if (!locked_s)              cnt <= '0;
          else if (cnt == LOCK_LAST) begin
            state <= HOLD;
            cnt   <= '0;
          end else                    cnt <= cnt + 1'b1;
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            o_rst[0] <= 1'b0;
            cnt      <= '0;
            if (CHANNELS == 1) begin
              state   <= RUN;
              o_ready <= 1'b1;
            end else begin
              state <= RELEASE;
              idx   <= IDX_W'(1);
            end
          end else cnt <= cnt + 1'b1;
        end
        RELEASE: begin
          if (cnt == STAG_LAST) begin
            cnt        <= '0;
            o_rst[idx] <= 1'b0;
            idx        <= idx + IDX_W'(1);
            if (idx == IDX_LAST) begin
              state   <= RUN;
              o_ready <= 1'b1;
            end
          end else cnt <= cnt + 1'b1;
        end
        RUN: begin
          // Software reset skips requalification since lock is still good.
          if (i_sw_rst) begin
            state   <= HOLD;
            cnt     <= '0;
            o_rst   <= '1;
            o_ready <= 1'b0;
          end
        end
        default: state <= QUALIFY;
      endcase
    end
  end

endmodule

// File: tb/tb_servant_reset_seq.sv
// Bench for servant_reset_seq: a default instance (A) and a single-channel,
// 2-bit-counter instance (B). Stimulus schedules expected output snapshots
// at absolute clock edges; a monitor compares them on the falling edge.
module tb_servant_reset_seq;

  logic       clk = 1'b0;
  logic       rst_a_n = 1'b1, locked_a = 1'b0, sw_a = 1'b0;
  logic       rst_b_n = 1'b1, locked_b = 1'b0, sw_b = 1'b0;
  logic [1:0] orst_a;
  logic       rdy_a;
  logic [7:0] cnt_a;
  logic [0:0] orst_b;
  logic       rdy_b;
  logic [1:0] cnt_b;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         cyc;
    int         dut;
    logic [1:0] rst;
    logic       rdy;
    logic [7:0] cnt;
    string      name;
  } exp_t;

  exp_t sb[$];

  servant_reset_seq dut_a (
    .i_clk(clk), .i_rst_n(rst_a_n), .i_locked(locked_a), .i_sw_rst(sw_a),
    .o_rst(orst_a), .o_ready(rdy_a), .o_lock_loss_cnt(cnt_a)
  );

  servant_reset_seq #(.CHANNELS(1), .LOSS_CNT_W(2)) dut_b (
    .i_clk(clk), .i_rst_n(rst_b_n), .i_locked(locked_b), .i_sw_rst(sw_b),
    .o_rst(orst_b), .o_ready(rdy_b), .o_lock_loss_cnt(cnt_b)
  );

  always #5 clk = ~clk;

  // Edge counter: cyc is the number of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every snapshot due at this edge; overdue ones fail.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        logic [1:0] r;
        logic       y;
        logic [7:0] n;
        if (sb[i].dut == 0) begin r = orst_a; y = rdy_a; n = cnt_a; end
        else begin r = {1'b0, orst_b}; y = rdy_b; n = {6'b0, cnt_b}; end
        n_cmp++;
        if (r !== sb[i].rst || y !== sb[i].rdy || n !== sb[i].cnt) begin
          n_bad++;
          $display("FAIL %s edge %0d dut%0d: got rst=%b rdy=%b cnt=%0d, want rst=%b rdy=%b cnt=%0d",
                   sb[i].name, cyc, sb[i].dut, r, y, n, sb[i].rst, sb[i].rdy, sb[i].cnt);
        end
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s expired: due edge %0d, now %0d", sb[i].name, sb[i].cyc, cyc);
        sb.delete(i);
      end
    end
  end

  task automatic expect_at(input int c, input int d, input logic [1:0] r,
                           input logic y, input logic [7:0] n, input string nm);
    exp_t e;
    e.cyc = c; e.dut = d; e.rst = r; e.rdy = y; e.cnt = n; e.name = nm;
    sb.push_back(e);
  endtask

  // Advance to just after rising edge n.
  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [7:0] sat3(input int v);
    return 8'((v > 3) ? 3 : v);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, r1, s, s2, c1, cb, run_at, e;

    #1;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    expect_at(2, 0, 2'b11, 1'b0, 8'd0, "a_reset_state");
    expect_at(2, 1, 2'b01, 1'b0, 8'd0, "b_reset_state");

    // Power-up with lock already high.
    wait_cyc(3);
    c0 = cyc;
    expect_at(c0 + 25, 0, 2'b11, 1'b0, 8'd0, "pwr_hold");
    expect_at(c0 + 26, 0, 2'b10, 1'b0, 8'd0, "pwr_rst0");
    expect_at(c0 + 29, 0, 2'b10, 1'b0, 8'd0, "pwr_stagger");
    expect_at(c0 + 30, 0, 2'b00, 1'b1, 8'd0, "pwr_ready");
    locked_a = 1'b1;
    rst_a_n  = 1'b1;

    // Lock loss in RUN: falls before edge c0+33, reassert at c0+35.
    wait_cyc(c0 + 32);
    expect_at(c0 + 34, 0, 2'b00, 1'b1, 8'd0, "loss_pre");
    expect_at(c0 + 35, 0, 2'b11, 1'b0, 8'd1, "loss_reassert");
    expect_at(c0 + 61, 0, 2'b11, 1'b0, 8'd1, "relock_hold");
    expect_at(c0 + 62, 0, 2'b10, 1'b0, 8'd1, "relock_rst0");
    expect_at(c0 + 66, 0, 2'b00, 1'b1, 8'd1, "relock_ready");
    locked_a = 1'b0;
    wait_cyc(c0 + 36);
    locked_a = 1'b1;
    r1 = c0 + 66;

    // Software reset sampled at edge s, held high through HOLD.
    wait_cyc(r1 + 2);
    s = r1 + 3;
    expect_at(s,      0, 2'b11, 1'b0, 8'd1, "sw_assert");
    expect_at(s + 7,  0, 2'b11, 1'b0, 8'd1, "sw_hold");
    expect_at(s + 8,  0, 2'b10, 1'b0, 8'd1, "sw_rst0");
    expect_at(s + 11, 0, 2'b10, 1'b0, 8'd1, "sw_stagger");
    expect_at(s + 12, 0, 2'b00, 1'b1, 8'd1, "sw_ready");
    sw_a = 1'b1;
    wait_cyc(s + 5);
    sw_a = 1'b0;

    // Async reset in the middle of RELEASE.
    wait_cyc(s + 14);
    sw_a = 1'b1;
    s2 = s + 15;
    wait_cyc(s2);
    sw_a = 1'b0;
    expect_at(s2 + 8, 0, 2'b10, 1'b0, 8'd1, "rel_mid");
    expect_at(s2 + 9, 0, 2'b11, 1'b0, 8'd0, "async_rst");
    wait_cyc(s2 + 9);
    rst_a_n = 1'b0;

    // One-cycle lock glitch during qualification restarts the count.
    wait_cyc(s2 + 11);
    c1 = cyc;
    expect_at(c1 + 26, 0, 2'b11, 1'b0, 8'd0, "glitch_norel");
    expect_at(c1 + 33, 0, 2'b11, 1'b0, 8'd0, "glitch_hold");
    expect_at(c1 + 34, 0, 2'b10, 1'b0, 8'd0, "glitch_rst0");
    expect_at(c1 + 38, 0, 2'b00, 1'b1, 8'd0, "glitch_ready");
    rst_a_n = 1'b1;
    wait_cyc(c1 + 7);
    locked_a = 1'b0;
    wait_cyc(c1 + 8);
    locked_a = 1'b1;
    wait_cyc(c1 + 40);

    // Single channel: o_rst[0] and o_ready change together at T0.
    cb = cyc;
    expect_at(cb + 25, 1, 2'b01, 1'b0, 8'd0, "b_hold");
    expect_at(cb + 26, 1, 2'b00, 1'b1, 8'd0, "b_ready");
    locked_b = 1'b1;
    rst_b_n  = 1'b1;
    run_at   = cb + 26;

    // Five lock losses from RUN; 2-bit counter saturates at 3.
    for (int i = 1; i <= 5; i++) begin
      wait_cyc(run_at + 1);
      e = run_at + 2;
      expect_at(e + 1,  1, 2'b00, 1'b1, sat3(i - 1), "b_run");
      expect_at(e + 2,  1, 2'b01, 1'b0, sat3(i),     "b_loss");
      expect_at(e + 27, 1, 2'b01, 1'b0, sat3(i),     "b_rehold");
      expect_at(e + 28, 1, 2'b00, 1'b1, sat3(i),     "b_rerun");
      locked_b = 1'b0;
      wait_cyc(e + 2);
      locked_b = 1'b1;
      run_at = e + 28;
    end
    wait_cyc(run_at + 3);

    foreach (sb[i]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s never checked (due edge %0d)", sb[i].name, sb[i].cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
